// File: rtl/forward_unit_pkg.sv
// Shared definitions for the operand-forwarding path and the decoder.
//   - RV32 opcode constants
//   - need_forward codes
//   - tracker entry record {valid, rd, wen, is_load}
//   - forward source select and the tracker match helper
package forward_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_RS2  = 2'b01;
    localparam logic [1:0] FWD_RS1  = 2'b10;
    localparam logic [1:0] FWD_BOTH = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
    } trk_entry_t;

    // Which result bus feeds the forward output during EX.
    typedef enum logic {
        SEL_EX  = 1'b0,
        SEL_MEM = 1'b1
    } fwd_sel_e;

    // A tracked producer satisfies a source only when it really writes that
    // register; x0 never matches.
    function automatic logic src_match(input trk_entry_t e, input logic [4:0] rs);
        return (rs != 5'd0) && e.valid && e.wen && (e.rd == rs);
    endfunction

endpackage

// File: rtl/forward_unit_opcode_decode.sv
// fwd_opcode_decode: combinational opcode classification for forwarding.
//   opcode_i   : 7-bit instruction opcode
//   uses_rs1_o : instruction reads rs1
//   uses_rs2_o : instruction reads rs2
//   wen_o      : opcode class writes rd (caller still qualifies rd != 0)
//   is_load_o  : instruction is a load
module fwd_opcode_decode
    import forward_unit_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       wen_o,
    output logic       is_load_o
);

    always_comb begin
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        wen_o      = 1'b0;
        is_load_o  = 1'b0;
        unique case (opcode_i)
            OP_R: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                wen_o      = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
            end
            OP_I: begin
                uses_rs1_o = 1'b1;
                wen_o      = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1_o = 1'b1;
                wen_o      = 1'b1;
                is_load_o  = 1'b1;
            end
            OP_STORE: begin
                uses_rs1_o = 1'b1;
            end
            // jalr reads rs1 for its target, but that operand is not routed
            // through the ALU forward bus, so it is not tracked as a use here.
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: begin
                wen_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/forward_unit.sv
// forward_unit: ID-stage producer side of the ALU operand-forwarding path.
// Tracks the instructions in EX (E0) and MEM (E1), decides forwarding for the
// ID instruction, registers that decision for the EX cycle, and stalls on
// load-use or split-producer hazards.
//   clk, reset       : clock; asynchronous active-low reset
//   id_valid         : ID holds a real instruction
//   id_opcode/rs1/rs2/rd : ID instruction fields
//   flush            : discard the ID instruction this cycle
//   ex_result        : result of the distance-1 producer
//   mem_result       : result of the distance-2 producer (load data for loads)
//   stall            : combinational; hold PC and IF/ID
//   need_forward     : registered forwarding code {rs1, rs2}
//   forward          : ex_result or mem_result per the registered select
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            flush,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    output logic            stall,
    output logic [1:0]      need_forward,
    output logic [XLEN-1:0] forward
);

    trk_entry_t e0_q, e0_d;
    trk_entry_t e1_q;
    logic [1:0] nf_q, nf_d;
    fwd_sel_e   sel_q, sel_d;

    logic uses_rs1, uses_rs2, op_wen, op_is_load;

    fwd_opcode_decode u_dec (
        .opcode_i   (id_opcode),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .wen_o      (op_wen),
        .is_load_o  (op_is_load)
    );

    logic m0_rs1, m1_rs1, m0_rs2, m1_rs2;
    logic hit_rs1, hit_rs2;
    fwd_sel_e src_rs1, src_rs2;
    logic active, load_use, conflict, advance;

    always_comb begin
        m0_rs1 = uses_rs1 && src_match(e0_q, id_rs1);
        m1_rs1 = uses_rs1 && src_match(e1_q, id_rs1);
        m0_rs2 = uses_rs2 && src_match(e0_q, id_rs2);
        m1_rs2 = uses_rs2 && src_match(e1_q, id_rs2);

        hit_rs1 = m0_rs1 || m1_rs1;
        hit_rs2 = m0_rs2 || m1_rs2;
        // Younger producer (E0) wins when both entries hold the register.
        src_rs1 = m0_rs1 ? SEL_EX : SEL_MEM;
        src_rs2 = m0_rs2 ? SEL_EX : SEL_MEM;

        active   = id_valid && !flush;
        // Load data is not available until MEM, so an E0 load cannot feed EX.
        load_use = active && (m0_rs1 || m0_rs2) && e0_q.is_load;
        // One forward bus cannot carry two different producers at once.
        conflict = active && hit_rs1 && hit_rs2 && (src_rs1 != src_rs2);
        stall    = load_use || conflict;
        advance  = active && !stall;

        e0_d = '0;
        nf_d = FWD_NONE;
        sel_d = SEL_EX;
        if (advance) begin
            e0_d.valid   = 1'b1;
            e0_d.rd      = id_rd;
            e0_d.wen     = op_wen && (id_rd != 5'd0);
            e0_d.is_load = op_is_load;
            nf_d         = {hit_rs1, hit_rs2};
            if (hit_rs1)      sel_d = src_rs1;
            else if (hit_rs2) sel_d = src_rs2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            nf_q  <= FWD_NONE;
            sel_q <= SEL_EX;
        end else begin
            e1_q  <= e0_q;
            e0_q  <= e0_d;
            nf_q  <= nf_d;
            sel_q <= sel_d;
        end
    end

    assign need_forward = nf_q;
    assign forward      = (sel_q == SEL_MEM) ? mem_result : ex_result;

endmodule

// File: tb/tb_forward_unit.sv
module tb_forward_unit;
    import forward_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush;
    logic [31:0] ex_result, mem_result;
    logic        stall;
    logic [1:0]  need_forward;
    logic [31:0] forward;

    int total = 0;
    int bad   = 0;

    forward_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .flush        (flush),
        .ex_result    (ex_result),
        .mem_result   (mem_result),
        .stall        (stall),
        .need_forward (need_forward),
        .forward      (forward)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an instruction in ID; settles before the next edge.
    task automatic issue(input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
        id_valid  = 1'b1;
        id_opcode = op;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0;
        id_rd = '0; flush = 1'b0; ex_result = 32'h0000_0011; mem_result = 32'h0000_0099;
        tick(); tick();
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_nf",    {30'b0, need_forward}, 32'd0);
        chk("rst_fwd",   forward, 32'h0000_0011);
        reset = 1'b1;

        // 1: add x5,x1,x2 ; add x6,x5,x7 -> rs1 from EX
        issue(OP_R, 5'd5, 5'd1, 5'd2, 1'b0);
        chk("s1_stall0", {31'b0, stall}, 32'd0);
        tick();
        chk("s1_nf_first", {30'b0, need_forward}, 32'd0);
        issue(OP_R, 5'd6, 5'd5, 5'd7, 1'b0);
        chk("s1_stall1", {31'b0, stall}, 32'd0);
        tick();
        chk("s1_nf", {30'b0, need_forward}, 32'd2);
        chk("s1_fwd", forward, 32'h0000_0011);

        // 2: addi x5 ; nop ; sub x8,x9,x5 -> rs2 from MEM
        mem_result = 32'h0000_0022;
        issue(OP_I, 5'd5, 5'd1, 5'd0, 1'b0); tick();
        issue(OP_I, 5'd0, 5'd0, 5'd0, 1'b0); tick();
        issue(OP_R, 5'd8, 5'd9, 5'd5, 1'b0);
        chk("s2_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("s2_nf", {30'b0, need_forward}, 32'd1);
        chk("s2_fwd", forward, 32'h0000_0022);
        // both entries write x5: E0 wins
        issue(OP_I, 5'd5, 5'd0, 5'd0, 1'b0); tick();
        issue(OP_I, 5'd5, 5'd0, 5'd0, 1'b0); tick();
        issue(OP_R, 5'd7, 5'd5, 5'd3, 1'b0);
        chk("s2b_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("s2b_nf", {30'b0, need_forward}, 32'd2);
        chk("s2b_fwd", forward, 32'h0000_0011);

        // 3: lw x5 ; add x6,x5,x5 -> one-cycle load-use stall, then 11 from MEM
        issue(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0); tick();
        issue(OP_R, 5'd6, 5'd5, 5'd5, 1'b0);
        chk("s3_stall", {31'b0, stall}, 32'd1);
        tick();
        chk("s3_nf_bubble", {30'b0, need_forward}, 32'd0);
        chk("s3_stall_gone", {31'b0, stall}, 32'd0);
        mem_result = 32'hDEAD_BEEF;
        tick();
        chk("s3_nf", {30'b0, need_forward}, 32'd3);
        chk("s3_fwd", forward, 32'hDEAD_BEEF);

        // 4: addi x1 ; addi x2 ; add x3,x2,x1 -> one-cycle conflict stall
        mem_result = 32'h0000_0044;
        issue(OP_I, 5'd1, 5'd0, 5'd0, 1'b0); tick();
        issue(OP_I, 5'd2, 5'd0, 5'd0, 1'b0); tick();
        issue(OP_R, 5'd3, 5'd2, 5'd1, 1'b0);
        chk("s4_stall", {31'b0, stall}, 32'd1);
        tick();
        chk("s4_nf_bubble", {30'b0, need_forward}, 32'd0);
        chk("s4_stall_gone", {31'b0, stall}, 32'd0);
        tick();
        chk("s4_nf", {30'b0, need_forward}, 32'd2);
        chk("s4_fwd", forward, 32'h0000_0044);

        // 5: x0 is never forwarded
        issue(OP_R, 5'd0, 5'd1, 5'd2, 1'b0); tick();
        issue(OP_R, 5'd6, 5'd0, 5'd0, 1'b0);
        chk("s5_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("s5_nf", {30'b0, need_forward}, 32'd0);
        // flush during load-use: no stall, bubble into E0
        issue(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0); tick();
        issue(OP_R, 5'd6, 5'd5, 5'd5, 1'b1);
        chk("s5_flush_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("s5_flush_nf", {30'b0, need_forward}, 32'd0);
        issue(OP_R, 5'd10, 5'd6, 5'd6, 1'b0);
        chk("s5_bubble_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("s5_bubble_nf", {30'b0, need_forward}, 32'd0);

        // 6: reset mid-stall clears immediately
        issue(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0); tick();
        issue(OP_R, 5'd6, 5'd5, 5'd5, 1'b0);
        chk("s6_stall_pre", {31'b0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("s6_rst_stall", {31'b0, stall}, 32'd0);
        chk("s6_rst_nf", {30'b0, need_forward}, 32'd0);
        chk("s6_rst_fwd", forward, 32'h0000_0011);
        id_valid = 1'b0;
        tick();
        reset = 1'b1;
        issue(OP_R, 5'd5, 5'd1, 5'd2, 1'b0); tick();
        issue(OP_R, 5'd6, 5'd5, 5'd7, 1'b0);
        chk("s6_post_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("s6_post_nf", {30'b0, need_forward}, 32'd2);
        chk("s6_post_fwd", forward, 32'h0000_0011);

        id_valid = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
